otp_stream_cipher: RTL and testbench
====================================

# otp_stream_cipher

Parametrised one-time-pad stream cipher with a valid/ready handshake and a tagged pad table. Encrypt requests XOR input data with a fresh pad from an internal 16-bit LFSR, store the pad in a DEPTH-entry table and return the slot index. Decrypt requests name a slot, XOR with the stored pad and burn it. The block sits between the chip pin mux and any downstream packet logic, replacing the fixed 8-bit, 8-slot encryptor.

## Interface
- DATA_W, 8, data/pad width; legal range 1..16.
- DEPTH, 8, pad table entries; power of two, at least 2; IDX_W = log2(DEPTH).
- SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  block enable; when low, in_ready is 0 and all state holds.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_mode  in  1  0 = encrypt, 1 = decrypt.
- in_data  in  DATA_W  plaintext for encrypt, ciphertext for decrypt.
- in_idx  in  IDX_W  pad slot for decrypt; ignored for encrypt.
- out_valid  out  1  result held in the output register.
- out_ready  in  1  consumer takes the result when out_valid & out_ready.
- out_data  out  DATA_W  result, or 0 when out_err is 1.
- out_idx  out  IDX_W  slot used by the request.
- out_err  out  1  request rejected; no state changed except the output register.
- pad_count  out  IDX_W+1  number of live (unused) pads.

## Operation
- Reset values:
  - out_valid=0, out_data=0, out_idx=0, out_err=0, pad_count=0.
  - wr_ptr=0, all live bits 0, table contents 0, lfsr=SEED.
- LFSR: 16-bit Fibonacci, shifting left. Feedback is lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10] into bit 0. pad = lfsr[DATA_W-1:0].
- Accepted encrypt, when live[wr_ptr]=0:
  - mem[wr_ptr] <= pad and live[wr_ptr] <= 1.
  - out_data <= in_data ^ pad and out_idx <= wr_ptr.
  - wr_ptr increments modulo DEPTH, the LFSR steps once and pad_count increments.
- Accepted encrypt, when live[wr_ptr]=1 (slot still unused):
  - out_err=1, out_data=0, out_idx=wr_ptr.
  - No write, no LFSR step, and wr_ptr holds.
  - This applies even if pad_count < DEPTH.
- Accepted decrypt, when live[in_idx]=1:
  - out_data <= in_data ^ mem[in_idx] and out_idx <= in_idx.
  - Burn: live[in_idx] <= 0, mem[in_idx] <= 0, pad_count decrements.
- Accepted decrypt, when live[in_idx]=0: out_err=1, out_data=0, out_idx=in_idx, no state change.
- Only one request is handled per cycle, so no table collisions can occur.

## Timing
- in_ready = ena & (~out_valid | out_ready), driven combinationally.
- Latency is 1 cycle: a request accepted at edge N is visible on out_* after edge N. out_valid is set at that edge.
- Output hold: out_data, out_idx and out_err are stable while out_valid & ~out_ready.
- out_valid clears on the edge where out_ready=1 and no new request is accepted.
- Back-to-back: with out_ready held at 1, one request is accepted per cycle at full throughput.
- ena low mid-stream: the pending output stays valid and can still drain through out_ready; no new request is accepted.
- pad_count updates on the same edge as the table.
- Reset mid-operation:
  - Immediately clears all outputs and the table; in-flight results are lost.
  - The LFSR restarts at SEED, so the pad sequence repeats after every reset.

## Configuration
- OTP_BURN_EN defined (production): decrypt burns the pad as described above.
- OTP_BURN_EN undefined (debug):
  - Decrypt leaves live and mem unchanged, so a pad can be reused any number of times.
  - pad_count is not decremented by decrypts.
  - Encrypt behaviour is identical in both builds.

## Test plan
- Reset, then encrypt 8'h5A with out_ready=1 -> out_idx=0, out_err=0, pad_count=1. out_data^8'h5A equals the SEED low byte (8'hE1).
- Encrypt 8'h5A, then decrypt in_idx=0 with the returned out_data -> out_data=8'h5A, pad_count=0. A second decrypt of idx 0 -> out_err=1, out_data=0.
- Fill the table: 8 encrypts give out_idx 0..7 and pad_count=8. A 9th encrypt -> out_err=1, out_idx=0, LFSR unchanged. After a decrypt of idx 0, the next encrypt succeeds at idx 0.
- Hold out_ready=0 after one result -> in_ready=0 and the output is stable for 5 cycles. Releasing out_ready -> the next request is accepted that cycle.
- Drop ena for 3 cycles in the middle of a burst -> no acceptance and no LFSR step. On resume, pads continue the original sequence.
- Assert rst_n=0 asynchronously while out_valid=1 -> out_valid falls before the next edge. The first encrypt afterwards reproduces the first pad seen after the initial reset.

Source files
------------

// File: rtl/otp_stream_cipher_if.sv
// rtl/otp_stream_cipher_if.sv - request/response handshake bundle for the one-time-pad cipher
interface otp_stream_cipher_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [DATA_W-1:0] in_data;
  logic [IDX_W-1:0]  in_idx;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_err;

  // requester / result consumer side
  modport master (
    output in_valid, in_mode, in_data, in_idx, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_err
  );

  // cipher side
  modport slave (
    input  in_valid, in_mode, in_data, in_idx, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_err
  );
endinterface

// File: rtl/otp_stream_cipher.sv
// rtl/otp_stream_cipher.sv - one-time-pad stream cipher with LFSR pads and tagged pad table (OTP_BURN_EN enables pad burn on decrypt)
module otp_stream_cipher #(
  parameter int          DATA_W = 8,
  parameter int          DEPTH  = 8,
  parameter logic [15:0] SEED   = 16'hACE1,
  localparam int         IDX_W  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  otp_stream_cipher_if.slave  bus,
  output logic [IDX_W:0]      pad_count
);

  // an all-zero LFSR would lock up, so a zero seed is promoted to 1
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0]                   lfsr_q, lfsr_d;
  logic [IDX_W-1:0]              wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0]              live_q, live_d;
  logic [DEPTH-1:0][DATA_W-1:0]  mem_q, mem_d;
  logic [IDX_W:0]                pad_count_q, pad_count_d;
  logic                          out_valid_q, out_valid_d;
  logic [DATA_W-1:0]             out_data_q, out_data_d;
  logic [IDX_W-1:0]              out_idx_q, out_idx_d;
  logic                          out_err_q, out_err_d;

  logic              lfsr_fb;
  logic [DATA_W-1:0] pad;
  logic              accept;

  assign lfsr_fb      = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign pad          = lfsr_q[DATA_W-1:0];
  assign bus.in_ready = ena & (~out_valid_q | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_err   = out_err_q;
  assign pad_count     = pad_count_q;

  // next-state: drain the output register, then serve at most one request
  always_comb begin
    lfsr_d      = lfsr_q;
    wr_ptr_d    = wr_ptr_q;
    live_d      = live_q;
    mem_d       = mem_q;
    pad_count_d = pad_count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_err_d   = out_err_q;

    if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      out_valid_d = 1'b1;
      out_err_d   = 1'b0;
      if (!bus.in_mode) begin
        out_idx_d = wr_ptr_q;
        // an unconsumed pad at the write pointer blocks encryption even if other slots are free
        if (live_q[wr_ptr_q]) begin
          out_err_d  = 1'b1;
          out_data_d = '0;
        end else begin
          mem_d[wr_ptr_q]  = pad;
          live_d[wr_ptr_q] = 1'b1;
          out_data_d       = bus.in_data ^ pad;
          wr_ptr_d         = wr_ptr_q + 1'b1;
          lfsr_d           = {lfsr_q[14:0], lfsr_fb};
          pad_count_d      = pad_count_q + 1'b1;
        end
      end else begin
        out_idx_d = bus.in_idx;
        if (live_q[bus.in_idx]) begin
          out_data_d = bus.in_data ^ mem_q[bus.in_idx];
`ifdef OTP_BURN_EN
          live_d[bus.in_idx] = 1'b0;
          mem_d[bus.in_idx]  = '0;
          pad_count_d        = pad_count_q - 1'b1;
`else
          // debug build: pads stay live so they can be replayed
`endif
        end else begin
          out_err_d  = 1'b1;
          out_data_d = '0;
        end
      end
    end
  end

  // state registers with asynchronous clear; LFSR restarts from the seed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q      <= SEED_EFF;
      wr_ptr_q    <= '0;
      live_q      <= '0;
      mem_q       <= '0;
      pad_count_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      wr_ptr_q    <= wr_ptr_d;
      live_q      <= live_d;
      mem_q       <= mem_d;
      pad_count_q <= pad_count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_err_q   <= out_err_d;
    end
  end

endmodule

// File: tb/tb_otp_stream_cipher.sv
// tb/tb_otp_stream_cipher.sv - self-checking bench for otp_stream_cipher
module tb_otp_stream_cipher;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int IDX_W  = 3;
`ifdef OTP_BURN_EN
  localparam bit BURN = 1'b1;
`else
  localparam bit BURN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           ena;
  logic [IDX_W:0] pad_count;

  otp_stream_cipher_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

  otp_stream_cipher #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SEED(16'hACE1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .bus       (bus),
    .pad_count (pad_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model: pad sequence by index, table as plain arrays
  logic [7:0] pads [1024];
  int         m_steps;
  int         m_wr;
  bit         m_live [DEPTH];
  logic [7:0] m_mem  [DEPTH];
  bit         m_ov;
  logic [7:0] m_od;
  int         m_oi;
  bit         m_oe;

  typedef struct {
    bit         mode;
    logic [7:0] data;
    int         idx;
    logic [7:0] exp_data;
    int         exp_idx;
    bit         exp_err;
    int         exp_cnt;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int live_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += m_live[i];
    return n;
  endfunction

  task automatic model_reset();
    m_steps = 0; m_wr = 0; m_ov = 0; m_od = 0; m_oi = 0; m_oe = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_live[i] = 0;
      m_mem[i]  = 0;
    end
  endtask

  task automatic drive(input bit v, input bit mode, input logic [7:0] data, input int idx);
    bus.in_valid = v;
    bus.in_mode  = mode;
    bus.in_data  = data;
    bus.in_idx   = idx[IDX_W-1:0];
  endtask

  // one clock: check handshake, apply the spec rules at the edge, check outputs
  task automatic tick();
    bit exp_rdy;
    bit acc;
    int ix;
    #1;
    exp_rdy = ena && (!m_ov || bus.out_ready);
    check("in_ready", bus.in_ready, exp_rdy);
    acc = bus.in_valid && exp_rdy;
    @(posedge clk);
    if (m_ov && bus.out_ready) m_ov = 0;
    if (acc) begin
      m_ov = 1;
      m_oe = 0;
      if (!bus.in_mode) begin
        m_oi = m_wr;
        if (m_live[m_wr]) begin
          m_oe = 1; m_od = 0;
        end else begin
          m_mem[m_wr]  = pads[m_steps];
          m_live[m_wr] = 1;
          m_od         = bus.in_data ^ pads[m_steps];
          m_wr         = (m_wr + 1) % DEPTH;
          m_steps++;
        end
      end else begin
        ix   = int'(bus.in_idx);
        m_oi = ix;
        if (m_live[ix]) begin
          m_od = bus.in_data ^ m_mem[ix];
          if (BURN) begin
            m_live[ix] = 0;
            m_mem[ix]  = 0;
          end
        end else begin
          m_oe = 1; m_od = 0;
        end
      end
    end
    @(negedge clk);
    check("out_valid", bus.out_valid, m_ov);
    check("out_data", bus.out_data, m_od);
    check("out_idx", bus.out_idx, m_oi);
    check("out_err", bus.out_err, m_oe);
    check("pad_count", pad_count, live_count());
  endtask

  task automatic sync_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [15:0] s;
    s = 16'hACE1;
    for (int i = 0; i < 1024; i++) begin
      pads[i] = s[7:0];
      s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    end

    // expected pads from ACE1: E1, C3, 87
    vecs[0] = '{0, 8'h5A, 0, 8'hBB, 0, 0, 1};
    vecs[1] = '{1, 8'hBB, 0, 8'h5A, 0, 0, BURN ? 0 : 1};
    if (BURN) vecs[2] = '{1, 8'hBB, 0, 8'h00, 0, 1, 0};
    else      vecs[2] = '{1, 8'hBB, 0, 8'h5A, 0, 0, 1};
    vecs[3] = '{0, 8'h00, 0, 8'hC3, 1, 0, BURN ? 1 : 2};
    vecs[4] = '{0, 8'hFF, 0, 8'h78, 2, 0, BURN ? 2 : 3};
    vecs[5] = '{1, 8'h11, 1, 8'hD2, 1, 0, BURN ? 1 : 3};

    rst_n = 1'b0;
    ena   = 1'b1;
    bus.out_ready = 1'b1;
    drive(0, 0, 8'h00, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_idx", bus.out_idx, 0);
    check("rst_out_err", bus.out_err, 0);
    check("rst_pad_count", pad_count, 0);
    rst_n = 1'b1;

    // table-driven basic encrypt/decrypt
    for (int i = 0; i < 6; i++) begin
      drive(1, vecs[i].mode, vecs[i].data, vecs[i].idx);
      tick();
      check("vec_data", bus.out_data, vecs[i].exp_data);
      check("vec_idx", bus.out_idx, vecs[i].exp_idx);
      check("vec_err", bus.out_err, vecs[i].exp_err);
      check("vec_cnt", pad_count, vecs[i].exp_cnt);
    end
    drive(0, 0, 8'h00, 0);
    tick();

    // fill the table, overflow, then free slot 0
    sync_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 8'($urandom), 0);
      tick();
      check("fill_idx", bus.out_idx, i);
      check("fill_err", bus.out_err, 0);
    end
    check("fill_cnt", pad_count, 8);
    drive(1, 0, 8'h00, 0);
    tick();
    check("full_err", bus.out_err, 1);
    check("full_idx", bus.out_idx, 0);
    check("full_data", bus.out_data, 0);
    drive(1, 1, 8'h00, 0);
    tick();
    drive(1, 0, 8'h00, 0);
    tick();
    check("refill_err", bus.out_err, BURN ? 0 : 1);
    check("refill_idx", bus.out_idx, 0);
    drive(0, 0, 8'h00, 0);
    tick();

    // backpressure: result held while out_ready is low
    sync_reset();
    bus.out_ready = 1'b0;
    drive(1, 0, 8'h5A, 0);
    tick();
    drive(1, 0, 8'h33, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_data", bus.out_data, 8'hBB);
      check("hold_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    check("release_data", bus.out_data, 8'hF0);
    check("release_idx", bus.out_idx, 1);

    // ena low mid-burst: no acceptance, no LFSR step
    sync_reset();
    drive(1, 0, 8'h00, 0);
    tick();
    tick();
    ena = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    ena = 1'b1;
    tick();
    check("resume_pad", bus.out_data, 8'h87);
    check("resume_idx", bus.out_idx, 2);

    // asynchronous reset while a result is pending
    bus.out_ready = 1'b0;
    drive(1, 0, 8'h12, 0);
    tick();
    check("pre_arst_valid", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", bus.out_valid, 0);
    check("arst_cnt", pad_count, 0);
    check("arst_data", bus.out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    bus.out_ready = 1'b1;
    drive(1, 0, 8'h00, 0);
    tick();
    check("arst_first_pad", bus.out_data, 8'hE1);

    // randomized traffic against the model
    sync_reset();
    for (int c = 0; c < 400; c++) begin
      ena = ($urandom_range(0, 7) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, DEPTH - 1));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
